rom_region_loader: RTL and testbench
====================================

Name: rom_region_loader

Overview:
- Parametrised, registered successor to the fixed combinational ROM download chip-select decode used between the MiSTer ioctl stream and the arcade PCB ROMs.
- Maps each ioctl byte write onto one of NUM_REGIONS address windows and emits a one-cycle-delayed, region-local write strobe, offset and data.
- Tracks per-region fill progress, download session state and unmapped-write errors, so the top level can hold the game in reset until every ROM is loaded.

Parameters:
- NUM_REGIONS, 4, number of ROM regions / chip-select outputs (1..16).
- ADDR_W, 25, ioctl address width.
- REGION_BASE, {25'h6000,25'h4000,25'h2000,25'h0000}, packed NUM_REGIONS*ADDR_W; field i = base byte address of region i.
- REGION_LOG2, {5'd12,5'd13,5'd13,5'd13}, packed NUM_REGIONS*5; field i = log2 of region i size in bytes (1..24).

Ports:
- clk_49m  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a ROM download session.
- ioctl_addr  in  ADDR_W  byte address of the current write.
- ioctl_data  in  8  write data.
- ioctl_wr  in  1  one-cycle write strobe.
- cs_o  out  NUM_REGIONS  one-hot region select, valid when wr_o=1.
- wr_o  out  1  registered write pulse.
- addr_o  out  24  offset within the region (ioctl_addr - base), upper bits zero.
- data_o  out  8  registered ioctl_data.
- busy  out  1  high in the LOADING state.
- done  out  1  high in the DONE state.
- region_loaded  out  NUM_REGIONS  bit i set once region i has received 2^REGION_LOG2[i] writes.
- err_unmapped  out  1  sticky: a write during LOADING hit no region.

Behaviour:
- Reset (synchronous): state=IDLE; every output 0; all byte counters 0.
- Decode: region i matches when REGION_BASE[i] <= ioctl_addr < REGION_BASE[i] + 2^REGION_LOG2[i]. On overlap, the lowest index wins; cs_o is always one-hot or zero.
- Pipeline: fixed 1-cycle latency. ioctl_wr at cycle N gives, at N+1: wr_o=1, cs_o=match, addr_o=offset, data_o=data. Between writes, wr_o and cs_o return to 0; addr_o and data_o hold their last values.
- wr_o fires only when state=LOADING (or is entering LOADING on this write) and a region matches. An unmapped write produces no wr_o and sets err_unmapped at N+1.
- States:
  - IDLE -> LOADING on ioctl_download=1.
  - LOADING -> DONE on ioctl_download falling (registered edge detect).
  - DONE -> LOADING on ioctl_download rising.
- Entering LOADING from DONE clears all counters, region_loaded and err_unmapped in the same cycle.
- ioctl_wr while ioctl_download=0 is ignored entirely: no outputs, no counting.
- Counters: region i counter is REGION_LOG2[i]+1 bits wide. It increments on each accepted write to region i and saturates at 2^REGION_LOG2[i]. region_loaded[i] asserts in the same cycle the counter reaches full.
- Rewrites of the same address still count; the counter does not track unique addresses.
- ioctl_download falling in the same cycle as ioctl_wr: the write is accepted, then the state moves to DONE.
- Reset asserted mid-download: everything clears immediately. If ioctl_download is still high after reset releases, the next cycle enters LOADING with counters at 0.
- Decode and offset arithmetic are unsigned, ADDR_W bits. The region end is computed at ADDR_W+1 bits so a region ending exactly at 2^ADDR_W does not wrap.

Test Plan:
- Reset with ioctl_download=1 and ioctl_wr pulsing → every output stays 0 while reset=1; busy=1 one cycle after reset falls.
- Defaults, download high, write addr 0x2005 data 0xA5 → next cycle wr_o=1, cs_o=4'b0010, addr_o=0x0005, data_o=0xA5; following cycle wr_o=0, cs_o=0.
- Write 4096 sequential bytes from 0x6000 → region_loaded=4'b1000 exactly on the wr_o cycle of byte 0x6FFF, not earlier; bits [2:0] remain 0.
- Write to 0x7000 → no wr_o, err_unmapped=1 and stays 1; drop ioctl_download → done=1, busy=0; raise it again → err_unmapped=0, region_loaded=0.
- Build with NUM_REGIONS=2, bases 0x0 and 0x100, REGION_LOG2=9 for both (overlapping), write 0x150 → cs_o=2'b01, addr_o=0x150 (lowest index wins).
- Write with ioctl_download=0, and a write coincident with ioctl_download falling → the first produces nothing; the second produces wr_o=1 and counts, then done=1.

Source files
------------

// File: rtl/rom_region_loader_if.sv
// ioctl download stream plus registered ROM-side write bus.
// master: ioctl source and ROM sink. slave: the loader.
interface rom_region_loader_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 25
);
    logic                   ioctl_download;
    logic [ADDR_W-1:0]      ioctl_addr;
    logic [7:0]             ioctl_data;
    logic                   ioctl_wr;
    logic [NUM_REGIONS-1:0] cs_o;
    logic                   wr_o;
    logic [23:0]            addr_o;
    logic [7:0]             data_o;
    logic                   busy;
    logic                   done;
    logic [NUM_REGIONS-1:0] region_loaded;
    logic                   err_unmapped;

    modport master (
        output ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
        input  cs_o, wr_o, addr_o, data_o,
        input  busy, done, region_loaded, err_unmapped
    );

    modport slave (
        input  ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
        output cs_o, wr_o, addr_o, data_o,
        output busy, done, region_loaded, err_unmapped
    );
endinterface

// File: rtl/rom_region_loader.sv
// ROM download decoder: maps ioctl byte writes onto NUM_REGIONS windows.
// Ports: clk_49m, reset (sync, active high), bus (slave modport):
//   ioctl_* in; cs_o/wr_o/addr_o/data_o registered write, 1-cycle latency;
//   busy/done session state; region_loaded fill flags; err_unmapped sticky.
module rom_region_loader #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {25'h6000, 25'h4000, 25'h2000, 25'h0000},
    parameter logic [NUM_REGIONS*5-1:0] REGION_LOG2 =
        {5'd12, 5'd13, 5'd13, 5'd13}
) (
    input logic                 clk_49m,
    input logic                 reset,
    rom_region_loader_if.slave  bus
);
    localparam int OW = (ADDR_W > 24) ? ADDR_W : 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;
    logic   dl_q;
    logic   in_win;
    logic   clr;

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] sel;
    logic [NUM_REGIONS-1:0] loaded;
    logic [OW-1:0]          off [NUM_REGIONS];
    logic [OW-1:0]          sel_off;
    logic                   found;
    logic                   acc;
    logic                   acc_hit;
    logic                   unmapped;

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state <= S_IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_n;
            dl_q  <= bus.ioctl_download;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (bus.ioctl_download) state_n = S_LOAD;
            S_LOAD: if (dl_q && !bus.ioctl_download) state_n = S_DONE;
            S_DONE: if (!dl_q && bus.ioctl_download) state_n = S_LOAD;
            default: state_n = S_IDLE;
        endcase
    end

    // The accept window includes the falling-edge cycle of LOADING, so a
    // write coincident with download dropping still lands.
    always_comb begin
        bus.busy = (state == S_LOAD);
        bus.done = (state == S_DONE);
        in_win   = (state == S_LOAD) || (state_n == S_LOAD);
        clr      = (state == S_DONE) && (state_n == S_LOAD);
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_reg
        localparam int L = int'(REGION_LOG2[g*5 +: 5]);
        localparam logic [ADDR_W-1:0] BASE = REGION_BASE[g*ADDR_W +: ADDR_W];
        // One extra bit so a window ending at 2^ADDR_W does not wrap.
        localparam logic [ADDR_W:0] LAST =
            {1'b0, BASE} + ((ADDR_W+1)'(1) << L);

        logic [L:0] cnt;

        assign hit[g] = (bus.ioctl_addr >= BASE) &&
                        ({1'b0, bus.ioctl_addr} < LAST);
        assign off[g] = OW'(bus.ioctl_addr - BASE);

        // Saturates at 2^L, so the MSB alone marks the region as full.
        always_ff @(posedge clk_49m) begin
            if (reset) begin
                cnt <= '0;
            end else if (clr) begin
                cnt <= (L+1)'(acc_hit && sel[g]);
            end else if (acc_hit && sel[g] && !cnt[L]) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign loaded[g] = cnt[L];
    end

    always_comb begin
        sel     = '0;
        sel_off = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i] && !found) begin
                sel[i]  = 1'b1;
                sel_off = off[i];
                found   = 1'b1;
            end
        end
    end

    assign acc      = bus.ioctl_wr && in_win;
    assign acc_hit  = acc && found;
    assign unmapped = acc && !found;
    assign bus.region_loaded = loaded;

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            bus.wr_o         <= 1'b0;
            bus.cs_o         <= '0;
            bus.addr_o       <= '0;
            bus.data_o       <= '0;
            bus.err_unmapped <= 1'b0;
        end else begin
            bus.wr_o <= acc_hit;
            bus.cs_o <= acc_hit ? sel : '0;
            if (acc_hit) begin
                bus.addr_o <= sel_off[23:0];
                bus.data_o <= bus.ioctl_data;
            end
            if (clr) begin
                bus.err_unmapped <= unmapped;
            end else if (unmapped) begin
                bus.err_unmapped <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rom_region_loader.sv
// Directed bench for rom_region_loader (default build plus overlap build).
module tb_rom_region_loader;
    logic clk_49m = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    logic early;

    always #5 clk_49m = ~clk_49m;

    rom_region_loader_if #(.NUM_REGIONS(4), .ADDR_W(25)) bus_a ();
    rom_region_loader_if #(.NUM_REGIONS(2), .ADDR_W(25)) bus_b ();

    assign bus_b.ioctl_download = bus_a.ioctl_download;
    assign bus_b.ioctl_addr     = bus_a.ioctl_addr;
    assign bus_b.ioctl_data     = bus_a.ioctl_data;
    assign bus_b.ioctl_wr       = bus_a.ioctl_wr;

    rom_region_loader dut_a (
        .clk_49m (clk_49m),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    rom_region_loader #(
        .NUM_REGIONS (2),
        .ADDR_W      (25),
        .REGION_BASE ({25'h100, 25'h000}),
        .REGION_LOG2 ({5'd9, 5'd9})
    ) dut_b (
        .clk_49m (clk_49m),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [24:0] addr,
                         input logic [7:0] data);
        bus_a.ioctl_wr   = wr;
        bus_a.ioctl_addr = addr;
        bus_a.ioctl_data = data;
    endtask

    function automatic logic [31:0] all_a();
        return 32'({bus_a.cs_o, bus_a.wr_o, bus_a.addr_o != 24'd0,
                    bus_a.data_o, bus_a.busy, bus_a.done,
                    bus_a.region_loaded, bus_a.err_unmapped});
    endfunction

    function automatic logic [31:0] all_b();
        return 32'({bus_b.cs_o, bus_b.wr_o, bus_b.addr_o != 24'd0,
                    bus_b.data_o, bus_b.busy, bus_b.done,
                    bus_b.region_loaded, bus_b.err_unmapped});
    endfunction

    initial begin
        bus_a.ioctl_download = 1'b1;
        drive(1'b0, 25'h2005, 8'hA5);

        for (int i = 0; i < 4; i++) begin
            bus_a.ioctl_wr = i[0];
            step();
            check("rst_a", all_a(), 32'h0);
            check("rst_b", all_b(), 32'h0);
        end

        reset = 1'b0;
        drive(1'b0, 25'h0, 8'h00);
        step();
        check("busy_after_rst", 32'(bus_a.busy), 32'h1);

        drive(1'b1, 25'h2005, 8'hA5);
        step();
        check("wr_o", 32'(bus_a.wr_o), 32'h1);
        check("cs_o", 32'(bus_a.cs_o), 32'h2);
        check("addr_o", 32'(bus_a.addr_o), 32'h5);
        check("data_o", 32'(bus_a.data_o), 32'hA5);
        drive(1'b0, 25'h0, 8'h00);
        step();
        check("wr_o_idle", 32'(bus_a.wr_o), 32'h0);
        check("cs_o_idle", 32'(bus_a.cs_o), 32'h0);
        check("addr_hold", 32'(bus_a.addr_o), 32'h5);
        check("data_hold", 32'(bus_a.data_o), 32'hA5);

        drive(1'b1, 25'h150, 8'h5A);
        step();
        check("ovl_a_cs", 32'(bus_a.cs_o), 32'h1);
        check("ovl_b_cs", 32'(bus_b.cs_o), 32'h1);
        check("ovl_b_addr", 32'(bus_b.addr_o), 32'h150);
        drive(1'b1, 25'h250, 8'h6B);
        step();
        check("ovl2_b_cs", 32'(bus_b.cs_o), 32'h2);
        check("ovl2_b_addr", 32'(bus_b.addr_o), 32'h150);
        check("ovl2_a_addr", 32'(bus_a.addr_o), 32'h250);
        drive(1'b0, 25'h0, 8'h00);
        step();

        early = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            drive(1'b1, 25'(32'h6000 + i), 8'(i));
            step();
            if (i < 4095) begin
                if (bus_a.region_loaded != 4'b0000) early = 1'b1;
            end else begin
                check("fill_wr", 32'(bus_a.wr_o), 32'h1);
                check("fill_loaded", 32'(bus_a.region_loaded), 32'h8);
            end
        end
        check("fill_early", 32'(early), 32'h0);

        drive(1'b1, 25'h6000, 8'hEE);
        step();
        check("sat_loaded", 32'(bus_a.region_loaded), 32'h8);

        drive(1'b1, 25'h7000, 8'h99);
        step();
        check("unm_wr", 32'(bus_a.wr_o), 32'h0);
        check("unm_err", 32'(bus_a.err_unmapped), 32'h1);
        drive(1'b0, 25'h0, 8'h00);
        step();
        check("unm_sticky", 32'(bus_a.err_unmapped), 32'h1);

        bus_a.ioctl_download = 1'b0;
        step();
        check("done", 32'({bus_a.done, bus_a.busy}), 32'h2);
        check("done_loaded", 32'(bus_a.region_loaded), 32'h8);
        bus_a.ioctl_download = 1'b1;
        step();
        check("reload_busy", 32'(bus_a.busy), 32'h1);
        check("reload_err", 32'(bus_a.err_unmapped), 32'h0);
        check("reload_loaded", 32'(bus_a.region_loaded), 32'h0);

        for (int i = 0; i < 4095; i++) begin
            drive(1'b1, 25'(32'h6000 + i), 8'(i));
            step();
        end
        check("part_loaded", 32'(bus_a.region_loaded), 32'h0);

        bus_a.ioctl_download = 1'b0;
        drive(1'b1, 25'h6FFF, 8'h77);
        step();
        check("fall_wr", 32'(bus_a.wr_o), 32'h1);
        check("fall_cs", 32'(bus_a.cs_o), 32'h8);
        check("fall_addr", 32'(bus_a.addr_o), 32'hFFF);
        check("fall_data", 32'(bus_a.data_o), 32'h77);
        check("fall_loaded", 32'(bus_a.region_loaded), 32'h8);
        check("fall_done", 32'(bus_a.done), 32'h1);
        drive(1'b0, 25'h0, 8'h00);
        step();

        drive(1'b1, 25'h2000, 8'h11);
        step();
        check("ign_wr", 32'(bus_a.wr_o), 32'h0);
        check("ign_cs", 32'(bus_a.cs_o), 32'h0);
        check("ign_data", 32'(bus_a.data_o), 32'h77);
        check("ign_err", 32'(bus_a.err_unmapped), 32'h0);
        drive(1'b0, 25'h0, 8'h00);

        bus_a.ioctl_download = 1'b1;
        step();
        drive(1'b1, 25'h2005, 8'h42);
        reset = 1'b1;
        step();
        check("mid_rst", all_a(), 32'h0);
        drive(1'b0, 25'h0, 8'h00);
        reset = 1'b0;
        step();
        check("mid_rst_busy", 32'(bus_a.busy), 32'h1);
        check("mid_rst_loaded", 32'(bus_a.region_loaded), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
